// File: rtl/exe_mem_stage_reg_pkg.sv
// Shared constants and types for the EXE/MEM stage register and its status register.
// Status register bit layout is {Z,C,N,V}.
package exe_mem_stage_reg_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int RF_ADDR_W_DEF = 4;
  localparam int SR_W          = 4;

  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  localparam logic [SR_W-1:0] SR_RST_DEF = 4'b0000;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

  function automatic logic [SR_W-1:0] sr_pack(input logic z, input logic c,
                                               input logic n, input logic v);
    logic [SR_W-1:0] s;
    s       = '0;
    s[SR_Z] = z;
    s[SR_C] = c;
    s[SR_N] = n;
    s[SR_V] = v;
    return s;
  endfunction

endpackage

// File: rtl/exe_mem_stage_reg_status_reg.sv
// Status register {Z,C,N,V}: synchronous reset, loads d when ld is high.
module status_reg
  import exe_mem_stage_reg_pkg::*;
#(
  parameter logic [SR_W-1:0] RST_VAL = SR_RST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SR_W-1:0] d,
  output logic [SR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE-stage back end: EXE/MEM pipeline register, status register and branch resolution.
// Define EXE_MEM_FWD_EN to expose the forwarding outputs fwd_valid/fwd_dest/fwd_data.
module exe_mem_stage_reg
  import exe_mem_stage_reg_pkg::*;
#(
  parameter int               DATA_W    = DATA_W_DEF,
  parameter int               RF_ADDR_W = RF_ADDR_W_DEF,
  parameter logic [SR_W-1:0]  SR_RST    = SR_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [SR_W-1:0]      alu_sr,
  input  logic                 s_bit,
  input  logic                 wb_en_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic [RF_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]    val_rm_in,
  input  logic                 b_in,
  input  logic [23:0]          imm24_in,
  input  logic [DATA_W-1:0]    pc_in,
  output logic [SR_W-1:0]      sr,
  output logic                 branch_taken,
  output logic [DATA_W-1:0]    branch_addr,
  output logic                 valid_out,
  output logic                 wb_en_out,
  output logic                 mem_r_en_out,
  output logic                 mem_w_en_out,
  output logic [DATA_W-1:0]    alu_result_out,
  output logic [DATA_W-1:0]    val_rm_out,
  output logic [RF_ADDR_W-1:0] dest_out
`ifdef EXE_MEM_FWD_EN
  ,
  output logic                 fwd_valid,
  output logic [RF_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]    fwd_data
`endif
);

  localparam int OFF_PAD = DATA_W - 26;

  logic            accept;
  ctrl_t           ctrl_d;
  ctrl_t           ctrl_q;
  logic [DATA_W-1:0] branch_off;

  assign accept = valid_in & ~freeze & ~flush;

  // Controls are gated by accept so a bubble can never carry a write enable.
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.valid    = accept;
    ctrl_d.wb_en    = accept & wb_en_in;
    ctrl_d.mem_r_en = accept & mem_r_en_in;
    ctrl_d.mem_w_en = accept & mem_w_en_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q         <= '0;
      alu_result_out <= '0;
      val_rm_out     <= '0;
      dest_out       <= '0;
    end else if (!freeze) begin
      ctrl_q         <= ctrl_d;
      alu_result_out <= alu_result;
      val_rm_out     <= val_rm_in;
      dest_out       <= dest_in;
    end
  end

  assign valid_out    = ctrl_q.valid;
  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;

  status_reg #(
    .RST_VAL (SR_RST)
  ) u_status_reg (
    .clk (clk),
    .rst (rst),
    .ld  (accept & s_bit),
    .d   (alu_sr),
    .q   (sr)
  );

  // Word offset, sign-extended; the add wraps modulo 2^DATA_W.
  assign branch_off   = {{OFF_PAD{imm24_in[23]}}, imm24_in, 2'b00};
  assign branch_addr  = pc_in + branch_off;
  assign branch_taken = valid_in & b_in & ~flush & ~freeze;

`ifdef EXE_MEM_FWD_EN
  assign fwd_valid = ctrl_q.valid & ctrl_q.wb_en & ~ctrl_q.mem_r_en;
  assign fwd_dest  = dest_out;
  assign fwd_data  = alu_result_out;
`endif

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Directed, table-driven bench for exe_mem_stage_reg (forwarding checks when EXE_MEM_FWD_EN is set).
module tb_exe_mem_stage_reg;
  import exe_mem_stage_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, freeze, flush, s_bit, wb_en_in, mem_r_en_in, mem_w_en_in, b_in;
  logic [31:0] alu_result, val_rm_in, pc_in;
  logic [3:0]  alu_sr, dest_in;
  logic [23:0] imm24_in;
  logic [3:0]  sr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_result_out, val_rm_out;
  logic [3:0]  dest_out;
`ifdef EXE_MEM_FWD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exe_mem_stage_reg dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .freeze         (freeze),
    .flush          (flush),
    .alu_result     (alu_result),
    .alu_sr         (alu_sr),
    .s_bit          (s_bit),
    .wb_en_in       (wb_en_in),
    .mem_r_en_in    (mem_r_en_in),
    .mem_w_en_in    (mem_w_en_in),
    .dest_in        (dest_in),
    .val_rm_in      (val_rm_in),
    .b_in           (b_in),
    .imm24_in       (imm24_in),
    .pc_in          (pc_in),
    .sr             (sr),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .valid_out      (valid_out),
    .wb_en_out      (wb_en_out),
    .mem_r_en_out   (mem_r_en_out),
    .mem_w_en_out   (mem_w_en_out),
    .alu_result_out (alu_result_out),
    .val_rm_out     (val_rm_out),
    .dest_out       (dest_out)
`ifdef EXE_MEM_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_dest       (fwd_dest),
    .fwd_data       (fwd_data)
`endif
  );

  typedef struct {
    logic v, fz, fl, s, wb, mr, mw, b;
    logic [3:0]  asr, dest;
    logic [31:0] res, rm, pc;
    logic [23:0] imm;
    logic        cb, ebt;
    logic [31:0] eba;
    logic        cd, ev, ewb, emr, emw;
    logic [3:0]  edest;
    logic [31:0] eres, erm;
    logic [3:0]  esr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_in    = t.v;   freeze      = t.fz;  flush    = t.fl;  s_bit = t.s;
    wb_en_in    = t.wb;  mem_r_en_in = t.mr;  mem_w_en_in = t.mw; b_in = t.b;
    alu_sr      = t.asr; dest_in     = t.dest; alu_result = t.res;
    val_rm_in   = t.rm;  pc_in       = t.pc;  imm24_in = t.imm;
  endtask

  initial begin
    //        v fz fl s wb mr mw b  asr   dest res        rm            pc            imm        cb ebt eba     cd ev ewb emr emw edest eres     erm           esr
    vecs[0]  = '{1,0,0,1,1,0,0,0, 4'h8, 3, 32'h0,     32'h0,        32'h0,        24'h0,      0,0, 32'h0,   1, 1,1,0,0, 3, 32'h0,    32'h0,        4'h8};
    vecs[1]  = '{1,1,0,1,1,0,0,0, 4'h5, 7, 32'h11,    32'h0,        32'h0,        24'h0,      0,0, 32'h0,   1, 1,1,0,0, 3, 32'h0,    32'h0,        4'h8};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{1,0,0,1,1,0,0,0, 4'h5, 7, 32'h11,    32'h0,        32'h0,        24'h0,      0,0, 32'h0,   1, 1,1,0,0, 7, 32'h11,   32'h0,        4'h5};
    vecs[5]  = '{1,0,0,0,0,0,0,1, 4'h0, 1, 32'h22,    32'h0,        32'h100,      24'hFFFFFE, 1,1, 32'hF8,  1, 1,0,0,0, 1, 32'h22,   32'h0,        4'h5};
    vecs[6]  = '{1,0,0,0,0,0,0,1, 4'h0, 2, 32'h33,    32'h0,        32'h100,      24'h000003, 1,1, 32'h10C, 1, 1,0,0,0, 2, 32'h33,   32'h0,        4'h5};
    vecs[7]  = '{1,0,0,0,0,0,0,1, 4'h0, 4, 32'h44,    32'h0,        32'hFFFFFFFC, 24'h000001, 1,1, 32'h0,   1, 1,0,0,0, 4, 32'h44,   32'h0,        4'h5};
    vecs[8]  = '{1,0,1,1,0,0,1,1, 4'h6, 9, 32'h55,    32'h77,       32'h200,      24'h000002, 1,0, 32'h208, 0, 0,0,0,0, 0, 32'h0,    32'h0,        4'h5};
    vecs[9]  = '{0,0,0,1,1,1,1,1, 4'hF, 9, 32'h66,    32'h0,        32'h10,       24'h0,      1,0, 32'h10,  0, 0,0,0,0, 0, 32'h0,    32'h0,        4'h5};
    vecs[10] = '{1,0,0,0,0,0,1,0, 4'h0, 0, 32'h1000,  32'hDEADBEEF, 32'h0,        24'h0,      0,0, 32'h0,   1, 1,0,0,1, 0, 32'h1000, 32'hDEADBEEF, 4'h5};
    vecs[11] = '{1,0,0,1,1,1,0,0, 4'h2, 5, 32'h2000,  32'h0,        32'h0,        24'h0,      0,0, 32'h0,   1, 1,1,1,0, 5, 32'h2000, 32'h0,        4'h2};
    vecs[12] = '{1,0,0,1,1,0,0,0, 4'h1, 6, 32'h5,     32'h0,        32'h0,        24'h0,      0,0, 32'h0,   1, 1,1,0,0, 6, 32'h5,    32'h0,        4'h1};
    vecs[13] = '{1,1,1,1,1,0,0,1, 4'hC, 8, 32'h99,    32'h0,        32'h100,      24'h0,      1,0, 32'h100, 1, 1,1,0,0, 6, 32'h5,    32'h0,        4'h1};
    vecs[14] = '{1,0,0,1,1,0,0,0, 4'hC, 8, 32'h99,    32'h0,        32'h0,        24'h0,      0,0, 32'h0,   1, 1,1,0,0, 8, 32'h99,   32'h0,        4'hC};

    // Reset held for two edges while the inputs toggle.
    rst = 1'b1;
    drive(vecs[5]);
    flush = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_sr",    {28'h0, sr}, 32'h0);
      chk("rst_valid", {31'h0, valid_out}, 32'h0);
      chk("rst_ctrl",  {29'h0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'h0);
      chk("rst_res",   alu_result_out, 32'h0);
      chk("rst_rm",    val_rm_out, 32'h0);
      chk("rst_dest",  {28'h0, dest_out}, 32'h0);
      chk("rst_bt",    {31'h0, branch_taken}, 32'h0);
      drive(vecs[c == 0 ? 10 : 11]);
      freeze = 1'b1;
      b_in   = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_bt", i), {31'h0, branch_taken}, {31'h0, vecs[i].ebt});
      if (vecs[i].cb) chk($sformatf("v%0d_ba", i), branch_addr, vecs[i].eba);
      @(posedge clk); #1;
      chk($sformatf("v%0d_sr", i),    {28'h0, sr}, {28'h0, vecs[i].esr});
      chk($sformatf("v%0d_ctrl", i),  {28'h0, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out},
          {28'h0, vecs[i].ev, vecs[i].ewb, vecs[i].emr, vecs[i].emw});
      if (vecs[i].cd) begin
        chk($sformatf("v%0d_res", i),  alu_result_out, vecs[i].eres);
        chk($sformatf("v%0d_rm", i),   val_rm_out, vecs[i].erm);
        chk($sformatf("v%0d_dest", i), {28'h0, dest_out}, {28'h0, vecs[i].edest});
      end
`ifdef EXE_MEM_FWD_EN
      chk($sformatf("v%0d_fwdv", i), {31'h0, fwd_valid},
          {31'h0, vecs[i].ev & vecs[i].ewb & ~vecs[i].emr});
      if (vecs[i].cd) begin
        chk($sformatf("v%0d_fwdd", i), {28'h0, fwd_dest}, {28'h0, vecs[i].edest});
        chk($sformatf("v%0d_fwdx", i), fwd_data, vecs[i].eres);
      end
`endif
    end

    // Reset wins over a simultaneous freeze and flush.
    @(negedge clk);
    drive(vecs[12]);
    rst = 1'b1; freeze = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("rstprio_sr",    {28'h0, sr}, 32'h0);
    chk("rstprio_valid", {31'h0, valid_out}, 32'h0);
    chk("rstprio_res",   alu_result_out, 32'h0);

    // SR becomes visible only after the accepting edge.
    @(negedge clk);
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    valid_in = 1'b1; s_bit = 1'b1; alu_sr = sr_pack(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("lat_sr_before", {28'h0, sr}, 32'h0);
    @(posedge clk); #1;
    chk("lat_sr_after",  {28'h0, sr}, 32'h3);
    chk("lat_valid",     {31'h0, valid_out}, 32'h1);

    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
